// File: rtl/req_ack_initiator.sv
// Initiator side of the single-pulse req/ack handshake: issues one req pulse per
// accepted command, grades the ack arrival time and reports it on a response strobe.
module req_ack_initiator #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 8,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_data,
    output logic          req,
    output logic [DW-1:0] req_data,
    input  logic          ack,
    output logic          rsp_valid,
    output logic [1:0]    rsp_status,
    output logic          stray_ack,
    output logic [CW-1:0] err_cnt
);

    localparam int             WCW          = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WCNT_ONE     = WCW'(1);
    localparam logic [WCW-1:0] WCNT_TWO     = WCW'(2);
    localparam logic [WCW-1:0] WCNT_TIMEOUT = WCW'(TIMEOUT);
    localparam logic [CW-1:0]  ERR_MAX      = '1;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_LATE    = 2'b01;
    localparam logic [1:0] ST_EARLY   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        GAP  = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [WCW-1:0]  r_wcnt;
    logic            r_req;
    logic [DW-1:0]   r_reqData;
    logic            r_rspValid;
    logic [1:0]      r_rspStatus;
    logic            r_strayAck;
    logic [CW-1:0]   r_errCnt;

    logic            w_accept;
    logic            w_complete;
    logic [1:0]      w_status;
    logic            w_stray;
    logic            w_errInc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                w_nextState = ack ? GAP : WAIT;
            end
            WAIT: begin
                if (ack || (r_wcnt == WCNT_TIMEOUT)) begin
                    w_nextState = GAP;
                end
            end
            GAP: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // An ack in the req cycle itself counts as early; a late ack still wins over timeout.
    always_comb begin
        cmd_ready  = rst_n & (r_state == IDLE);
        w_accept   = cmd_ready & cmd_valid;
        w_complete = 1'b0;
        w_status   = ST_OK;
        w_stray    = ack & ((r_state == IDLE) | (r_state == GAP));
        case (r_state)
            REQ: begin
                if (ack) begin
                    w_complete = 1'b1;
                    w_status   = ST_EARLY;
                end
            end
            WAIT: begin
                if (ack) begin
                    w_complete = 1'b1;
                    if (r_wcnt == WCNT_ONE) begin
                        w_status = ST_EARLY;
                    end else if (r_wcnt == WCNT_TWO) begin
                        w_status = ST_OK;
                    end else begin
                        w_status = ST_LATE;
                    end
                end else if (r_wcnt == WCNT_TIMEOUT) begin
                    w_complete = 1'b1;
                    w_status   = ST_TIMEOUT;
                end
            end
            default: begin
                w_complete = 1'b0;
            end
        endcase
        w_errInc = (w_complete & (w_status != ST_OK)) | w_stray;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wcnt <= '0;
        end else if ((r_state == REQ) && !ack) begin
            r_wcnt <= WCNT_ONE;
        end else if ((r_state == WAIT) && !w_complete) begin
            r_wcnt <= r_wcnt + WCNT_ONE;
        end else begin
            r_wcnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req       <= 1'b0;
            r_reqData   <= '0;
            r_rspValid  <= 1'b0;
            r_rspStatus <= ST_OK;
            r_strayAck  <= 1'b0;
        end else begin
            r_req      <= w_accept;
            r_rspValid <= w_complete;
            r_strayAck <= w_stray;
            if (w_accept) begin
                r_reqData <= cmd_data;
            end
            if (w_complete) begin
                r_rspStatus <= w_status;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_errCnt <= '0;
        end else if (w_errInc && (r_errCnt != ERR_MAX)) begin
            r_errCnt <= r_errCnt + CW'(1);
        end
    end

    assign req        = r_req;
    assign req_data   = r_reqData;
    assign rsp_valid  = r_rspValid;
    assign rsp_status = r_rspStatus;
    assign stray_ack  = r_strayAck;
    assign err_cnt    = r_errCnt;

endmodule

// File: tb/tb_req_ack_initiator.sv
// Bench for req_ack_initiator: directed handshake scenarios followed by random traffic,
// all checked each cycle against a cycle-arithmetic model of the transaction timeline.
module tb_req_ack_initiator;

    localparam int DW      = 8;
    localparam int TIMEOUT = 8;
    localparam int CW      = 4;
    localparam int ERR_MAX = (1 << CW) - 1;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_data  = '0;
    logic          req;
    logic [DW-1:0] req_data;
    logic          ack       = 1'b0;
    logic          rsp_valid;
    logic [1:0]    rsp_status;
    logic          stray_ack;
    logic [CW-1:0] err_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a transaction is described by the cycle its req fires in.
    int            cyc       = 0;
    bit            mBusy     = 0;
    bit            mGap      = 0;
    int            mReqCycle = 0;
    logic [DW-1:0] eReqData  = '0;
    bit            eRspValid = 0;
    logic [1:0]    eStatus   = 2'b00;
    bit            eStray    = 0;
    int            eErr      = 0;

    int            cmdsLeft    = 0;
    logic [DW-1:0] nextData    = '0;
    int            planDelay   = 99;
    int            planLen     = 1;
    int            ackRemain   = 0;
    int            strayPct    = 0;
    int            resetPct    = 0;
    int            resetAtK    = -1;
    bit            forceReset  = 1;
    bit            randomPlan  = 0;
    bit            randomValid = 0;
    int            reqCycles[$];
    int            rspSeen     = 0;

    req_ack_initiator #(.DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .stray_ack  (stray_ack),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: observed %0h, required %0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic bumpErr();
        if (eErr < ERR_MAX) eErr++;
    endtask

    // Advance the model across one rising edge using the inputs of the cycle that just ended.
    task automatic modelUpdate();
        int k;
        eStray    = 0;
        eRspValid = 0;
        if (!rst_n) begin
            mBusy    = 0;
            mGap     = 0;
            eReqData = '0;
            eStatus  = 2'b00;
            eErr     = 0;
        end else if (mBusy) begin
            k = cyc - mReqCycle;
            if (ack || k == TIMEOUT) begin
                if (!ack)        eStatus = 2'b11;
                else if (k <= 1) eStatus = 2'b10;
                else if (k == 2) eStatus = 2'b00;
                else             eStatus = 2'b01;
                eRspValid = 1;
                mBusy     = 0;
                mGap      = 1;
                if (eStatus != 2'b00) bumpErr();
            end
        end else begin
            if (ack) begin
                eStray = 1;
                bumpErr();
            end
            if (mGap) begin
                mGap = 0;
            end else if (cmd_valid) begin
                eReqData  = cmd_data;
                mBusy     = 1;
                mReqCycle = cyc + 1;
                cmdsLeft--;
                nextData  = DW'($urandom);
                if (randomPlan) begin
                    planDelay = $urandom_range(0, TIMEOUT + 1);
                    planLen   = $urandom_range(1, 3);
                end
            end
        end
        cyc++;
    endtask

    task automatic applyStimulus();
        int k;
        k = cyc - mReqCycle;
        rst_n = !forceReset;
        if (resetAtK >= 0 && mBusy && k == resetAtK) begin
            rst_n    = 1'b0;
            resetAtK = -1;
        end
        if (resetPct > 0 && $urandom_range(0, 99) < resetPct) rst_n = 1'b0;
        cmd_valid = (cmdsLeft > 0) && (!randomValid || $urandom_range(0, 3) != 0);
        cmd_data  = cmd_valid ? nextData : DW'($urandom);
        if (ackRemain > 0) begin
            ack = 1'b1;
            ackRemain--;
        end else if (mBusy && k == planDelay) begin
            ack       = 1'b1;
            ackRemain = planLen - 1;
        end else begin
            ack = !mBusy && strayPct > 0 && $urandom_range(0, 99) < strayPct;
        end
    endtask

    task automatic compareAll();
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(rst_n && !mBusy && !mGap));
        checkOutput("req", 32'(req), 32'(mBusy && cyc == mReqCycle));
        checkOutput("req_data", 32'(req_data), 32'(eReqData));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(eRspValid));
        if (eRspValid) checkOutput("rsp_status", 32'(rsp_status), 32'(eStatus));
        checkOutput("stray_ack", 32'(stray_ack), 32'(eStray));
        checkOutput("err_cnt", 32'(err_cnt), 32'(eErr));
        if (req === 1'b1) reqCycles.push_back(cyc);
        if (rsp_valid === 1'b1) rspSeen++;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelUpdate();
        #1;
        applyStimulus();
        @(negedge clk);
        compareAll();
    endtask

    task automatic doTxn(input int n, input logic [DW-1:0] data, input int delay, input int len);
        bit done;
        done      = 0;
        cmdsLeft  = n;
        nextData  = data;
        planDelay = delay;
        planLen   = len;
        for (int i = 0; i < 60 * n + 40; i++) begin
            stepCycle();
            if (cmdsLeft <= 0 && !mBusy && !mGap && ackRemain == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) checkOutput("txnBudget", 32'(0), 32'(1));
        cmdsLeft = 0;
    endtask

    initial begin
        forceReset = 1;
        repeat (3) stepCycle();
        forceReset = 0;

        doTxn(1, 8'hA5, 2, 1);
        checkOutput("errAfterOk", 32'(err_cnt), 32'(0));
        doTxn(1, 8'h11, 4, 1);
        doTxn(1, 8'h22, 1, 1);
        doTxn(1, 8'h33, 0, 1);
        doTxn(1, 8'h44, 99, 1);

        reqCycles.delete();
        doTxn(3, 8'h55, 2, 1);
        checkOutput("reqCount", 32'(reqCycles.size()), 32'(3));
        if (reqCycles.size() == 3) begin
            checkOutput("reqSpacing1", 32'(reqCycles[1] - reqCycles[0]), 32'(5));
            checkOutput("reqSpacing2", 32'(reqCycles[2] - reqCycles[1]), 32'(5));
        end

        ackRemain = 1;
        repeat (3) stepCycle();
        doTxn(1, 8'h66, 2, 2);
        stepCycle();

        rspSeen  = 0;
        resetAtK = 1;
        doTxn(1, 8'h77, 2, 1);
        stepCycle();
        checkOutput("rspAfterReset", 32'(rspSeen), 32'(0));
        checkOutput("errAfterReset", 32'(err_cnt), 32'(0));
        doTxn(1, 8'h3C, 2, 1);

        for (int i = 0; i < ERR_MAX + 4; i++) doTxn(1, DW'($urandom), 1, 1);
        checkOutput("errSat", 32'(err_cnt), 32'(ERR_MAX));

        randomPlan  = 1;
        randomValid = 1;
        strayPct    = 8;
        resetPct    = 1;
        cmdsLeft    = 150;
        for (int i = 0; i < 6000 && cmdsLeft > 0; i++) stepCycle();
        if (cmdsLeft > 0) checkOutput("randBudget", 32'(0), 32'(1));
        cmdsLeft = 0;
        strayPct = 0;
        resetPct = 0;
        repeat (20) stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
